// File: rtl/latch_arb_pkg.sv
// Shared types and default constants for the shared-latch write arbiter.
// The FSM state encoding is also visible on the top level's state_dbg output.
package latch_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_HOLD_CYCLES = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set req bit after last_owner,
// wrapping modulo N_REQ, wins.
module rr_pick
    import latch_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid      = 1'b0;
        winner_idx = '0;
        winner_oh  = '0;
        cand       = '0;
        // Offsets 1..N_REQ visit last_owner itself last, so it has lowest priority.
        for (int off = 1; off <= N_REQ; off++) begin
            cand = IDX_W'((int'(last_owner) + off) % N_REQ);
            if (!valid && req[cand]) begin
                valid      = 1'b1;
                winner_idx = cand;
            end
        end
        if (valid) begin
            winner_oh[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/latch_write_arbiter.sv
// Round-robin owner of a shared enable-gated latch: grants one requester,
// holds latch_en for HOLD_CYCLES clocks, then pulses ack to that requester.
module latch_write_arbiter
    import latch_arb_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic                   latch_en,
    output logic [WIDTH-1:0]       latch_d,
    output logic [1:0]             state_dbg
);

    // Handshake: req is a level held until ack; a granted requester keeps its
    // wdata slice stable while grant is high; ack is a one-cycle commit pulse
    // and the requester either drops req at the next edge or re-arbitrates.

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             en_q, en_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .last_owner (last_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            en_q    <= 1'b0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ack_d   = '0;
        en_d    = en_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = HOLD;
                    grant_d = pick_oh;
                    en_d    = 1'b1;
                    cnt_d   = CNT_LOAD;
                    last_d  = pick_idx;
                end
            end
            HOLD: begin
                // Owner may drop req here; the write still runs to completion.
                if (cnt_q == '0) begin
                    state_d = RELEASE;
                    en_d    = 1'b0;
                    ack_d   = grant_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                en_d    = 1'b0;
            end
        endcase
    end

    always_comb begin
        latch_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                latch_d = latch_d | wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign grant     = grant_q;
    assign ack       = ack_q;
    assign latch_en  = en_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: directed scenarios then random traffic on a
// HOLD_CYCLES=2 and a HOLD_CYCLES=1 instance, checked against a timeline model.
module tb_latch_write_arbiter;
    import latch_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clock = 1'b0;
    logic reset;

    logic [N-1:0]   req_v   [2];
    logic [N*W-1:0] wdata_v [2];
    logic [N-1:0]   grant_v [2];
    logic [N-1:0]   ack_v   [2];
    logic           busy_v  [2];
    logic           en_v    [2];
    logic [W-1:0]   d_v     [2];
    logic [1:0]     st_v    [2];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Reference model: a transaction is a start edge plus an owner; all outputs
    // follow from the distance to the start edge.
    bit m_busy  [2];
    int m_start [2];
    int m_owner [2];
    int m_last  [2];
    int en_cnt  [2];
    int busy_cnt[2];

    logic [N-1:0] exp_q[$];

    latch_write_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(2)) u_dut (
        .clock(clock), .reset(reset), .req(req_v[0]), .wdata(wdata_v[0]),
        .grant(grant_v[0]), .ack(ack_v[0]), .busy(busy_v[0]), .latch_en(en_v[0]),
        .latch_d(d_v[0]), .state_dbg(st_v[0])
    );

    latch_write_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(1)) u_dut_h1 (
        .clock(clock), .reset(reset), .req(req_v[1]), .wdata(wdata_v[1]),
        .grant(grant_v[1]), .ack(ack_v[1]), .busy(busy_v[1]), .latch_en(en_v[1]),
        .latch_d(d_v[1]), .state_dbg(st_v[1])
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int hold_of(int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k]  = 1'b0;
            m_start[k] = 0;
            m_owner[k] = 0;
            m_last[k]  = N - 1;
        end
        exp_q.delete();
    endtask

    task automatic model_edge(int k, logic [N-1:0] r);
        int h;
        h = hold_of(k);
        if (m_busy[k]) begin
            if (cyc - m_start[k] == h + 1) m_busy[k] = 1'b0;
        end else if (r != '0) begin
            for (int s = 1; s <= N; s++) begin
                if (r[(m_last[k] + s) % N]) begin
                    m_owner[k] = (m_last[k] + s) % N;
                    break;
                end
            end
            m_last[k]  = m_owner[k];
            m_busy[k]  = 1'b1;
            m_start[k] = cyc;
            if (k == 0) exp_q.push_back(N'(1) << m_owner[k]);
        end
    endtask

    task automatic compare_all(int k);
        int           h;
        int           d;
        logic [N-1:0] eg;
        logic [N-1:0] ea;
        logic         ee;
        logic [W-1:0] ed;
        arb_state_t   es;
        h  = hold_of(k);
        d  = cyc - m_start[k];
        eg = '0;
        if (m_busy[k]) eg[m_owner[k]] = 1'b1;
        ee = m_busy[k] && (d < h);
        ea = (m_busy[k] && d == h) ? eg : '0;
        ed = m_busy[k] ? wdata_v[k][m_owner[k]*W +: W] : '0;
        es = !m_busy[k] ? IDLE : ((d < h) ? HOLD : RELEASE);
        check($sformatf("grant%0d", k), grant_v[k], eg);
        check($sformatf("latch_en%0d", k), en_v[k], ee);
        check($sformatf("ack%0d", k), ack_v[k], ea);
        check($sformatf("busy%0d", k), busy_v[k], m_busy[k]);
        check($sformatf("latch_d%0d", k), d_v[k], ed);
        check($sformatf("state%0d", k), st_v[k], es);
        if (k == 0 && ack_v[0] != '0) begin
            if (exp_q.size() > 0) check("sb_ack_order", ack_v[0], exp_q.pop_front());
            else                  check("sb_ack_extra", ack_v[0], 0);
        end
        if (en_v[k])   en_cnt[k]++;
        if (busy_v[k]) busy_cnt[k]++;
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        if (reset) begin
            for (int k = 0; k < 2; k++) model_edge(k, req_v[k]);
        end
        #1;
        for (int k = 0; k < 2; k++) compare_all(k);
    endtask

    task automatic wait_grant(int k, output int idx);
        int n;
        n = 0;
        while (grant_v[k] == '0 && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("grant_wait%0d", k), grant_v[k] != '0, 1);
        idx = -1;
        for (int i = 0; i < N; i++) if (grant_v[k][i]) idx = i;
    endtask

    task automatic wait_ack(int k, int i);
        int n;
        n = 0;
        while (ack_v[k][i] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("ack_wait%0d_%0d", k, i), ack_v[k][i], 1);
    endtask

    task automatic drive_random(int k);
        int h;
        int d;
        bit own;
        h = hold_of(k);
        d = cyc - m_start[k];
        for (int i = 0; i < N; i++) begin
            own = m_busy[k] && (m_owner[k] == i);
            if (own && d == h) begin
                if ($urandom_range(3) != 0) req_v[k][i] = 1'b0;
            end else if (own && d < h && req_v[k][i]) begin
                if ($urandom_range(7) == 0) req_v[k][i] = 1'b0;
            end else if (!own && !req_v[k][i]) begin
                wdata_v[k][i*W +: W] = W'($urandom);
                if ($urandom_range(2) == 0) req_v[k][i] = 1'b1;
            end
        end
    endtask

    initial begin
        int idx;
        int prev;
        int c0;

        reset      = 1'b0;
        req_v[0]   = '0;
        req_v[1]   = '0;
        wdata_v[0] = {$urandom, $urandom};
        wdata_v[1] = {$urandom, $urandom};
        model_reset();
        #2;
        check("rst_grant", grant_v[0], 0);
        check("rst_busy", busy_v[0], 0);
        check("rst_latch_en", en_v[1], 0);
        check("rst_latch_d", d_v[0], 0);
        repeat (2) tick();
        reset = 1'b1;

        // Single requester 2 with data A5.
        en_cnt[0] = 0; busy_cnt[0] = 0;
        wdata_v[0][2*W +: W] = 8'hA5;
        req_v[0] = 4'b0100;
        wait_grant(0, idx);
        check("t1_owner", idx, 2);
        check("t1_latch_d", d_v[0], 8'hA5);
        wait_ack(0, 2);
        req_v[0] = '0;
        tick();
        check("t1_en_cycles", en_cnt[0], 2);
        check("t1_busy_cycles", busy_cnt[0], 3);

        // All four request together straight out of reset.
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
        req_v[0] = 4'b1111;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            wait_grant(0, idx);
            check("t2_order", idx, g);
            if (g > 0) check("t2_period", cyc - prev, 4);
            prev = cyc;
            wait_ack(0, g);
            req_v[0][g] = 1'b0;
            tick();
        end

        // Two requesters holding req continuously must alternate.
        req_v[0] = 4'b0011;
        prev = -1;
        for (int g = 0; g < 6; g++) begin
            wait_grant(0, idx);
            check("t3_alt", idx, g % 2);
            check("t3_no_repeat", idx == prev, 0);
            prev = idx;
            wait_ack(0, idx);
            tick();
        end
        req_v[0] = '0;
        tick();

        // Owner drops req one cycle after grant.
        en_cnt[0] = 0;
        req_v[0] = 4'b0010;
        wait_grant(0, idx);
        check("t4_owner", idx, 1);
        tick();
        req_v[0][1] = 1'b0;
        wait_ack(0, 1);
        tick();
        check("t4_en_cycles", en_cnt[0], 2);

        // Asynchronous reset in the middle of HOLD aborts the write.
        req_v[0] = 4'b0001;
        wait_grant(0, idx);
        tick();
        check("t5_in_hold", en_v[0], 1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_grant_drop", grant_v[0], 0);
        check("t5_en_drop", en_v[0], 0);
        check("t5_busy_drop", busy_v[0], 0);
        check("t5_no_ack", ack_v[0], 0);
        model_reset();
        req_v[0] = '0;
        repeat (2) tick();
        reset = 1'b1;
        req_v[0] = 4'b1000;
        tick();
        check("t5_regrant", grant_v[0], 4'b1000);
        wait_ack(0, 3);
        req_v[0] = 4'b1111;
        tick();
        wait_grant(0, idx);
        check("t5_next_owner", idx, 0);
        wait_ack(0, 0);
        req_v[0] = '0;
        tick();

        // HOLD_CYCLES=1 instance: 1-cycle enable, 3-cycle period.
        en_cnt[1] = 0; busy_cnt[1] = 0;
        req_v[1] = 4'b0001;
        wait_grant(1, idx);
        check("t6_owner", idx, 0);
        c0 = cyc;
        wait_ack(1, 0);
        tick();
        wait_grant(1, idx);
        check("t6_period", cyc - c0, 3);
        wait_ack(1, 0);
        req_v[1] = '0;
        tick();
        check("t6_en_cycles", en_cnt[1], 2);
        check("t6_busy_cycles", busy_cnt[1], 4);

        // Random traffic on both instances.
        for (int t = 0; t < 600; t++) begin
            tick();
            drive_random(0);
            drive_random(1);
        end
        req_v[0] = '0;
        req_v[1] = '0;
        repeat (8) tick();
        check("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
